aesl_deadlock_monitor_gen: RTL and testbench
============================================

# aesl_deadlock_monitor_gen

Parametrised deadlock monitor for the co-simulation harness. It watches N AXI-stream block flags, per-instance block flags and per-instance idle flags of one dataflow region, and drives the same one-cycle-registered `block` flag as the per-instance monitors. It also adds a persistence filter, a sticky `deadlock` flag, first-offender capture and a saturating stall-duration counter, so a single parametrised block replaces the per-index generated monitors.

## Interface
Parameters:
- `NUM_AXIS`, 2, number of AXI-stream block inputs (≥1)
- `NUM_INST`, 5, number of sub-instance idle inputs (≥1)
- `NUM_BLK`, 1, number of sub-instance block inputs (≥1)
- `THRESH`, 16, consecutive blocked cycles required to declare deadlock (≥1)
- `CNT_W`, 16, width of the stall-duration counter

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `enable` in 1: monitor armed; when 0, FSM is held in IDLE
- `axis_mask` in NUM_AXIS: per-channel enable; a 0 bit ignores that channel
- `axis_block_sigs` in NUM_AXIS: per-channel stream-blocked flag
- `inst_idle_sigs` in NUM_INST: sub-instance idle flags
- `inst_block_sigs` in NUM_BLK: sub-instance blocked flags
- `clear` in 1: synchronous release of a latched deadlock
- `block` out 1: registered raw block condition
- `deadlock` out 1: sticky, persistence-filtered deadlock
- `first_idx` out IDX_W = $clog2(NUM_AXIS+1): offender captured on entering SUSPECT
- `stall_cycles` out CNT_W: cycles spent in DEADLOCK, saturating

## Operation
- all_idle = &inst_idle_sigs.
- raw = ~all_idle & (|(axis_block_sigs & axis_mask) | |inst_block_sigs). A fully idle region is never blocked.
- `block` is registered raw, with no enable gating. Behaviour is identical to the legacy monitors.
- FSM states:
  - IDLE:
    - enable & raw: go to SUSPECT, cnt=1, capture `first_idx`.
    - If THRESH==1: go directly to DEADLOCK instead.
  - SUSPECT:
    - ~raw or ~enable: go to IDLE, cnt=0.
    - raw and cnt==THRESH-1: go to DEADLOCK.
    - Otherwise cnt+1.
  - DEADLOCK:
    - Sticky regardless of raw or enable.
    - clear: go to IDLE, cnt=0, stall_cycles=0, first_idx=0.
- `first_idx` is the lowest index i with axis_block_sigs[i]&axis_mask[i]. If only inst_block_sigs caused raw, `first_idx` = NUM_AXIS. It is held through SUSPECT and DEADLOCK and is not updated while blocked.
- `deadlock` = (state==DEADLOCK), registered.
- `stall_cycles` increments once per cycle in DEADLOCK and saturates at 2^CNT_W−1. It is not wrapped. It holds its value outside DEADLOCK until clear.
- Internal cnt width is $clog2(THRESH+1). cnt never exceeds THRESH.
- `clear` has priority over every transition except reset. `clear` in IDLE or SUSPECT forces IDLE with cnt=0. clear with raw=1 in the same cycle: stay IDLE that cycle; re-arm is evaluated on the next edge.

## Timing
- Reset values: block=0, deadlock=0, first_idx=0, stall_cycles=0, state=IDLE, cnt=0. Reset acts immediately on assertion, mid-count included, and releases synchronously on the next rising edge.
- `block` latency: 1 cycle from raw.
- `deadlock` latency: rises after the THRESH-th consecutive edge with enable&raw sampled high. A raw pulse of THRESH−1 cycles never sets it.
- `stall_cycles` reads 1 on the first edge after `deadlock` rises.
- Release: `deadlock` falls 1 edge after clear is sampled.

## Test plan
- THRESH=4, mask=2'b11, inst_idle=5'b00000; raw via axis[1] held 3 cycles then dropped -> block high for 3 cycles, deadlock stays 0, first_idx=1 during SUSPECT.
- Same setup, axis[0]|axis[1] held 10 cycles -> deadlock rises exactly 4 edges after the first sample; first_idx=0; stall_cycles=6 at the end; deadlock still 1 after raw drops.
- axis_block_sigs=2'b11, axis_mask=2'b00, inst_block=1 -> deadlock after THRESH cycles with first_idx=2; with inst_idle=5'b11111 -> block=0, no deadlock.
- CNT_W=3, stall held 12 cycles -> stall_cycles saturates at 7; clear -> deadlock=0, stall_cycles=0 one edge later; clear with raw=1 -> re-enters SUSPECT one edge after clear.
- Reset asserted mid-SUSPECT (cnt=2) and mid-DEADLOCK, asynchronously between edges -> all outputs 0 immediately; a new count starts from 1 after release.
- THRESH=1 -> deadlock and block rise on the same edge; enable=0 with raw=1 -> block follows raw, deadlock stays 0.

Source files
------------

// File: rtl/aesl_deadlock_monitor_gen.sv
`timescale 1ns/1ps
// aesl_deadlock_monitor_gen
// Region-wide deadlock monitor for the co-simulation harness. It registers the
// raw block condition exactly like the per-instance monitors, and adds a
// persistence filter of THRESH cycles, a sticky deadlock flag, capture of the
// first offending stream, and a saturating stall-duration counter.
module aesl_deadlock_monitor_gen #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 5,
  parameter int NUM_BLK  = 1,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_AXIS-1:0]           axis_mask,
  input  logic [NUM_AXIS-1:0]           axis_block_sigs,
  input  logic [NUM_INST-1:0]           inst_idle_sigs,
  input  logic [NUM_BLK-1:0]            inst_block_sigs,
  input  logic                          clear,
  output logic                          block,
  output logic                          deadlock,
  output logic [$clog2(NUM_AXIS+1)-1:0] first_idx,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int IDX_W = $clog2(NUM_AXIS + 1);
  localparam int THR_W = $clog2(THRESH + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SUSPECT  = 2'd1;
  localparam logic [1:0] ST_DEADLOCK = 2'd2;

  // Count value at which one more blocked cycle completes the filter window.
  localparam logic [THR_W-1:0] CNT_LAST  = THR_W'(THRESH - 1);
  localparam logic [THR_W-1:0] CNT_ONE   = THR_W'(1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_INST  = IDX_W'(NUM_AXIS);

  logic                all_idle;
  logic [NUM_AXIS-1:0] axis_hits;
  logic                raw;
  logic                armed_raw;
  logic [IDX_W-1:0]    hit_idx;

  logic                block_q, block_d;
  logic [1:0]          state_q, state_d;
  logic [THR_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  // Raw block condition: something is blocked and the region is not fully idle.
  always_comb begin
    all_idle  = &inst_idle_sigs;
    axis_hits = axis_block_sigs & axis_mask;
    raw       = ~all_idle & ((|axis_hits) | (|inst_block_sigs));
    armed_raw = enable & raw;
    block_d   = raw;
  end

  // Lowest-index enabled blocked stream; NUM_AXIS means only instances blocked.
  always_comb begin
    hit_idx = IDX_INST;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (axis_hits[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Persistence filter, sticky deadlock, offender capture and stall counting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_idx_d = first_idx_q;
    stall_d     = stall_q;
    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      first_idx_d = '0;
      stall_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_raw) begin
            first_idx_d = hit_idx;
            cnt_d       = CNT_ONE;
            state_d     = (THRESH == 1) ? ST_DEADLOCK : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (!armed_raw) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DEADLOCK;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DEADLOCK: begin
          if (stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      first_idx_q <= '0;
      stall_q     <= '0;
    end else begin
      block_q     <= block_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_idx_q <= first_idx_d;
      stall_q     <= stall_d;
    end
  end

  assign block        = block_q;
  assign deadlock     = (state_q == ST_DEADLOCK);
  assign first_idx    = first_idx_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_aesl_deadlock_monitor_gen.sv
`timescale 1ns/1ps
// Bench for aesl_deadlock_monitor_gen: two instances share one stimulus set,
// instance a with THRESH=4/CNT_W=3 and instance b with THRESH=1/CNT_W=16.
module tb_aesl_deadlock_monitor_gen;

  localparam int NA = 2;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  axis_mask;
  logic [1:0]  axis_block_sigs;
  logic [4:0]  inst_idle_sigs;
  logic [0:0]  inst_block_sigs;
  logic        clear;

  logic        block_a, deadlock_a;
  logic [1:0]  first_idx_a;
  logic [2:0]  stall_a;
  logic        block_b, deadlock_b;
  logic [1:0]  first_idx_b;
  logic [15:0] stall_b;

  // Reference model: consecutive armed-blocked run length per instance.
  bit m_blk[2];
  bit m_dl[2];
  int m_run[2];
  int m_fidx[2];
  int m_stall[2];
  int m_thr[2] = '{4, 1};
  int m_max[2] = '{7, 65535};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  aesl_deadlock_monitor_gen #(
    .NUM_AXIS(2), .NUM_INST(5), .NUM_BLK(1), .THRESH(4), .CNT_W(3)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .axis_mask(axis_mask),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .clear(clear), .block(block_a),
    .deadlock(deadlock_a), .first_idx(first_idx_a), .stall_cycles(stall_a)
  );

  aesl_deadlock_monitor_gen #(
    .NUM_AXIS(2), .NUM_INST(5), .NUM_BLK(1), .THRESH(1), .CNT_W(16)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .axis_mask(axis_mask),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .clear(clear), .block(block_b),
    .deadlock(deadlock_b), .first_idx(first_idx_b), .stall_cycles(stall_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] act_a();
    return {block_a, deadlock_a, first_idx_a, stall_a};
  endfunction

  function automatic logic [19:0] act_b();
    return {block_b, deadlock_b, first_idx_b, stall_b};
  endfunction

  function automatic logic [6:0] exp_a();
    return {m_blk[0], m_dl[0], 2'(m_fidx[0]), 3'(m_stall[0])};
  endfunction

  function automatic logic [19:0] exp_b();
    return {m_blk[1], m_dl[1], 2'(m_fidx[1]), 16'(m_stall[1])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_blk[k] = 0; m_dl[k] = 0; m_run[k] = 0; m_fidx[k] = 0; m_stall[k] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs as sampled at that edge.
  task automatic model_step();
    logic [1:0] hits;
    bit raw;
    int low;
    hits = axis_block_sigs & axis_mask;
    raw  = (inst_idle_sigs != 5'h1f) && ((hits != 0) || (inst_block_sigs != 0));
    low  = NA;
    for (int i = 0; i < NA; i++) begin
      if (hits[i] && low == NA) low = i;
    end
    for (int k = 0; k < 2; k++) begin
      m_blk[k] = raw;
      if (clear) begin
        m_dl[k] = 0; m_run[k] = 0; m_fidx[k] = 0; m_stall[k] = 0;
      end else if (m_dl[k]) begin
        if (m_stall[k] < m_max[k]) m_stall[k]++;
      end else if (enable && raw) begin
        if (m_run[k] == 0) m_fidx[k] = low;
        m_run[k]++;
        if (m_run[k] >= m_thr[k]) m_dl[k] = 1;
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  // Inputs change on the falling edge; the model steps on the rising edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; axis_mask = 2'b11; axis_block_sigs = 2'b00;
    inst_idle_sigs = 5'b00000; inst_block_sigs = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #3;
    if (act_a() !== 7'd0) begin
      failures++; $display("[TB] FAIL reset_a got=%h exp=0", act_a());
    end
    checks++;
    if (act_b() !== 20'd0) begin
      failures++; $display("[TB] FAIL reset_b got=%h exp=0", act_b());
    end
    checks++;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    tick();
    if (act_a() !== exp_a()) begin
      failures++; $display("[TB] FAIL reset_idle_a got=%h exp=%h", act_a(), exp_a());
    end
    checks++;
  endtask

  task automatic test_short_pulse();
    axis_block_sigs = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) axis_block_sigs = 2'b00;
      tick();
      if (act_a() !== exp_a()) begin
        failures++; $display("[TB] FAIL pulse_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
      end
      checks++;
      if (act_b() !== exp_b()) begin
        failures++; $display("[TB] FAIL pulse_b cyc=%0d got=%h exp=%h", cyc, act_b(), exp_b());
      end
      checks++;
      if (i < 3 && (block_a !== 1'b1 || first_idx_a !== 2'd1 || deadlock_a !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL pulse_suspect i=%0d got blk=%b idx=%0d dl=%b exp blk=1 idx=1 dl=0",
                 i, block_a, first_idx_a, deadlock_a);
      end
      checks++;
    end
    if (block_a !== 1'b0 || deadlock_a !== 1'b0) begin
      failures++; $display("[TB] FAIL pulse_drop got blk=%b dl=%b exp 0 0", block_a, deadlock_a);
    end
    checks++;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_deadlock_axis();
    axis_block_sigs = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (act_a() !== exp_a()) begin
        failures++; $display("[TB] FAIL axis_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
      end
      checks++;
      if ((i == 3 && deadlock_a !== 1'b0) || (i == 4 && deadlock_a !== 1'b1)) begin
        failures++; $display("[TB] FAIL axis_latency edge=%0d got dl=%b", i, deadlock_a);
      end
      checks++;
    end
    if (stall_a !== 3'd6 || first_idx_a !== 2'd0) begin
      failures++; $display("[TB] FAIL axis_end got stall=%0d idx=%0d exp stall=6 idx=0", stall_a, first_idx_a);
    end
    checks++;
    axis_block_sigs = 2'b00;
    tick();
    if (deadlock_a !== 1'b1 || stall_a !== 3'd7 || block_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL axis_sticky got dl=%b stall=%0d blk=%b exp dl=1 stall=7 blk=0", deadlock_a, stall_a, block_a);
    end
    checks++;
    clear = 1'b1; tick(); clear = 1'b0;
    if (act_a() !== 7'd0) begin
      failures++; $display("[TB] FAIL axis_clear got=%h exp=0", act_a());
    end
    checks++;
  endtask

  task automatic test_inst_block();
    axis_block_sigs = 2'b11; axis_mask = 2'b00; inst_block_sigs = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (act_a() !== exp_a()) begin
        failures++; $display("[TB] FAIL inst_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
      end
      checks++;
    end
    if (deadlock_a !== 1'b1 || first_idx_a !== 2'd2) begin
      failures++; $display("[TB] FAIL inst_dl got dl=%b idx=%0d exp dl=1 idx=2", deadlock_a, first_idx_a);
    end
    checks++;
    clear = 1'b1; tick(); clear = 1'b0;
    inst_idle_sigs = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (block_a !== 1'b0 || deadlock_a !== 1'b0 || block_b !== 1'b0 || deadlock_b !== 1'b0) begin
        failures++;
        $display("[TB] FAIL all_idle i=%0d got a=%b%b b=%b%b exp 00 00", i, block_a, deadlock_a, block_b, deadlock_b);
      end
      checks++;
    end
    idle_inputs();
  endtask

  task automatic test_saturate_clear();
    axis_block_sigs = 2'b01;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (act_a() !== exp_a()) begin
        failures++; $display("[TB] FAIL sat_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
      end
      checks++;
    end
    if (stall_a !== 3'd7) begin
      failures++; $display("[TB] FAIL sat_value got=%0d exp=7", stall_a);
    end
    checks++;
    axis_block_sigs = 2'b10; clear = 1'b1;
    tick();
    clear = 1'b0;
    if (deadlock_a !== 1'b0 || stall_a !== 3'd0 || first_idx_a !== 2'd0) begin
      failures++;
      $display("[TB] FAIL clear_release got dl=%b stall=%0d idx=%0d exp 0 0 0", deadlock_a, stall_a, first_idx_a);
    end
    checks++;
    tick();
    if (first_idx_a !== 2'd1 || deadlock_a !== 1'b0) begin
      failures++; $display("[TB] FAIL rearm got idx=%0d dl=%b exp idx=1 dl=0", first_idx_a, deadlock_a);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (act_a() !== exp_a()) begin
        failures++; $display("[TB] FAIL rearm_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
      end
      checks++;
    end
    if (deadlock_a !== 1'b1) begin
      failures++; $display("[TB] FAIL rearm_dl got=%b exp=1", deadlock_a);
    end
    checks++;
    axis_block_sigs = 2'b00; clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_async_reset();
    axis_block_sigs = 2'b01;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < ((pass == 0) ? 2 : 6); i++) tick();
      #2;
      reset = 1'b0;
      #1;
      if (act_a() !== 7'd0 || act_b() !== 20'd0) begin
        failures++; $display("[TB] FAIL async_reset pass=%0d got a=%h b=%h exp 0", pass, act_a(), act_b());
      end
      checks++;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        tick();
        if (act_a() !== exp_a() || (i == 3 && deadlock_a !== 1'b0) || (i == 4 && deadlock_a !== 1'b1)) begin
          failures++; $display("[TB] FAIL post_reset pass=%0d edge=%0d got=%h exp=%h", pass, i, act_a(), exp_a());
        end
        checks++;
      end
    end
    axis_block_sigs = 2'b00; clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_thresh_one();
    axis_block_sigs = 2'b10;
    tick();
    if (block_b !== 1'b1 || deadlock_b !== 1'b1 || first_idx_b !== 2'd1) begin
      failures++;
      $display("[TB] FAIL thresh1 got blk=%b dl=%b idx=%0d exp 1 1 1", block_b, deadlock_b, first_idx_b);
    end
    checks++;
    axis_block_sigs = 2'b00; clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b0; axis_block_sigs = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (block_a !== 1'b1 || block_b !== 1'b1 || deadlock_a !== 1'b0 || deadlock_b !== 1'b0) begin
        failures++;
        $display("[TB] FAIL disabled i=%0d got a=%b%b b=%b%b exp 10 10", i, block_a, deadlock_a, block_b, deadlock_b);
      end
      checks++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int hold;
    int n;
    n = 0;
    while (n < 400) begin
      enable          = ($urandom_range(7) != 0);
      axis_block_sigs = 2'($urandom);
      axis_mask       = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      inst_idle_sigs  = ($urandom_range(5) == 0) ? 5'h1f : 5'($urandom);
      inst_block_sigs = 1'($urandom);
      clear           = ($urandom_range(15) == 0);
      hold            = $urandom_range(6, 1);
      for (int h = 0; h < hold; h++) begin
        tick();
        n++;
        clear = 1'b0;
        if (act_a() !== exp_a()) begin
          failures++; $display("[TB] FAIL rand_a cyc=%0d got=%h exp=%h", cyc, act_a(), exp_a());
        end
        checks++;
        if (act_b() !== exp_b()) begin
          failures++; $display("[TB] FAIL rand_b cyc=%0d got=%h exp=%h", cyc, act_b(), exp_b());
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_deadlock_axis();
    test_inst_block();
    test_saturate_clear();
    test_async_reset();
    test_thresh_one();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
